pixel_sequencer: RTL

Frame-level controller for the 4-pixel sensor array. It sequences the global ERASE → EXPOSE → CONVERT phases and then enables READ1..READ4 one at a time. During each read it samples the shared 8-bit DATA bus into a 4×8 frame register and presents the finished frame on a valid/ready output. It sits between the system/readout logic and the pixel array, and replaces hand-driven testbench stimulus for the array control lines.

---
 rtl/pixel_sequencer.sv | 107 ++++++++++
 1 files changed

// File: rtl/pixel_sequencer.sv
// pixel_sequencer: sequences erase/expose/convert, then reads the four pixels
// into a frame register and hands the frame off over valid/ready.
module pixel_sequencer #(
    parameter int C_ERASE    = 5,
    parameter int C_EXPOSE   = 255,
    parameter int C_CONVERT  = 255,
    parameter int C_READ     = 4,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        erase,
    output logic        expose,
    output logic        convert,
    output logic        cnt_reset,
    output logic        cnt_en,
    output logic [3:0]  read,
    input  logic [7:0]  data_in,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic [31:0] frame_data
);
    localparam int MAX_A = C_ERASE > C_EXPOSE ? C_ERASE : C_EXPOSE;
    localparam int MAX_B = C_CONVERT > C_READ ? C_CONVERT : C_READ;
    localparam int CW    = $clog2((MAX_A > MAX_B ? MAX_A : MAX_B) + 1);

    typedef enum logic [2:0] {IDLE, ERASE, EXPOSE, CONVERT, READ, OUTPUT} state_t;

    state_t        state, nxt;
    logic [CW-1:0] cnt, nxt_cnt;
    logic [1:0]    pix, nxt_pix;
    logic          cap, done, handoff;

    assign done    = cnt == '0;
    assign handoff = frame_valid && frame_ready;

    always_comb begin
        nxt     = state;
        nxt_cnt = done ? cnt : cnt - 1'b1;
        nxt_pix = pix;
        cap     = 1'b0;
        case (state)
            IDLE: if (start) begin
                nxt     = ERASE;
                nxt_cnt = CW'(C_ERASE - 1);
            end
            ERASE: if (done) begin
                nxt     = EXPOSE;
                nxt_cnt = CW'(C_EXPOSE - 1);
            end
            EXPOSE: if (done) begin
                nxt     = CONVERT;
                nxt_cnt = CW'(C_CONVERT - 1);
            end
            CONVERT: if (done) begin
                nxt     = READ;
                nxt_cnt = CW'(C_READ - 1);
                nxt_pix = 2'd0;
            end
            READ: if (done) begin
                cap     = 1'b1;
                nxt     = pix == 2'd3 ? OUTPUT : READ;
                nxt_cnt = pix == 2'd3 ? cnt : CW'(C_READ - 1);
                nxt_pix = pix == 2'd3 ? pix : pix + 2'd1;
            end
            OUTPUT: if (handoff) begin
                nxt     = CONTINUOUS ? ERASE : IDLE;
                nxt_cnt = CONTINUOUS ? CW'(C_ERASE - 1) : cnt;
            end
            default: nxt = IDLE;
        endcase
    end

    // control outputs are registered from the next state so they align with it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            pix         <= 2'd0;
            busy        <= 1'b0;
            erase       <= 1'b0;
            expose      <= 1'b0;
            convert     <= 1'b0;
            cnt_reset   <= 1'b0;
            cnt_en      <= 1'b0;
            read        <= 4'b0000;
            frame_valid <= 1'b0;
            frame_data  <= '0;
        end else begin
            state       <= nxt;
            cnt         <= nxt_cnt;
            pix         <= nxt_pix;
            busy        <= nxt != IDLE;
            erase       <= nxt == ERASE;
            expose      <= nxt == EXPOSE;
            convert     <= nxt == CONVERT;
            cnt_reset   <= nxt == ERASE;
            cnt_en      <= nxt == CONVERT;
            read        <= nxt == READ ? 4'b0001 << nxt_pix : 4'b0000;
            frame_valid <= state == OUTPUT && !handoff;
            if (cap)
                frame_data[{pix, 3'b000} +: 8] <= data_in;
        end
    end
endmodule
